// File: rtl/sort_engine_if.sv
// Stream and control bundle for sort_engine.
// The producer, consumer and control handshakes share one interface.
interface sort_engine_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             start;
    logic             busy;
    logic             done;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;

    modport slave (
        input  in_valid,
        input  in_data,
        input  start,
        input  out_ready,
        output in_ready,
        output busy,
        output done,
        output out_valid,
        output out_data,
        output count
    );

    modport master (
        output in_valid,
        output in_data,
        output start,
        output out_ready,
        input  in_ready,
        input  busy,
        input  done,
        input  out_valid,
        input  out_data,
        input  count
    );
endinterface

// File: rtl/sort_engine.sv
// Buffered in-place bubble sorter sharing one magnitude comparator.
// Loads words, sorts with one compare-and-swap per cycle, then drains.
module sort_engine #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    sort_engine_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] SORT  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    fill;
    logic [CW-1:0]    pass;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    rd_ptr;
    logic             swapped;
    logic [WIDTH-1:0] mem [DEPTH];

    logic [IW-1:0]    nxt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             gt;
    logic [CW-1:0]    limit;
    logic             single;
    logic             last_cmp;
    logic             sort_exit;
    logic             swap;
    logic             load_xfer;
    logic             go;
    logic             drain_hs;
    logic             last_out;

    assign nxt = idx + IW'(1);
    assign a   = mem[idx];
    assign b   = mem[nxt];
    assign gt  = a > b;

    assign limit    = fill - CW'(2) - pass;
    assign single   = (fill == CW'(1));
    assign last_cmp = (CW'(idx) == limit);

    // A pass ends the sort when it made no swap or was the length-one pass
    assign sort_exit = single |
                       (last_cmp & (~(swapped | gt) | (limit == '0)));

    assign swap = (state == SORT) & ~single & gt;

    assign bus.in_ready = (state == LOAD) & (fill < CW'(DEPTH));
    assign load_xfer    = bus.in_valid & bus.in_ready;
    assign go           = (state == LOAD) & bus.start &
                          ((fill != '0) | load_xfer);

    assign drain_hs = (state == DRAIN) & bus.out_ready;
    assign last_out = (CW'(rd_ptr) == fill - CW'(1));

    assign bus.busy      = (state == SORT) | (state == DRAIN);
    assign bus.done      = (state == SORT) & sort_exit;
    assign bus.out_valid = (state == DRAIN);
    assign bus.out_data  = (state == DRAIN) ? mem[rd_ptr] : '0;
    assign bus.count     = fill;

    // Buffer contents are intentionally left unreset
    always_ff @(posedge clk) begin
        if (load_xfer) begin
            mem[fill[IW-1:0]] <= bus.in_data;
        end else if (swap) begin
            mem[idx] <= b;
            mem[nxt] <= a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOAD;
            fill    <= '0;
            pass    <= '0;
            idx     <= '0;
            rd_ptr  <= '0;
            swapped <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (load_xfer) begin
                        fill <= fill + CW'(1);
                    end
                    if (go) begin
                        state   <= SORT;
                        idx     <= '0;
                        pass    <= '0;
                        swapped <= 1'b0;
                    end
                end
                SORT: begin
                    if (sort_exit) begin
                        state  <= DRAIN;
                        rd_ptr <= '0;
                    end else if (last_cmp) begin
                        pass    <= pass + CW'(1);
                        idx     <= '0;
                        swapped <= 1'b0;
                    end else begin
                        idx     <= nxt;
                        swapped <= swapped | gt;
                    end
                end
                DRAIN: begin
                    if (drain_hs) begin
                        if (last_out) begin
                            state  <= LOAD;
                            fill   <= '0;
                            rd_ptr <= '0;
                        end else begin
                            rd_ptr <= rd_ptr + IW'(1);
                        end
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sort_engine.sv
// Testbench for sort_engine: vector table plus scoreboard queue.
// Covers reset, empty start, full buffer, stalls and mid-sort reset.
module tb_sort_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sort_engine_if #(.WIDTH(8), .DEPTH(8)) bus ();

    sort_engine #(.WIDTH(8), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int              n;
        logic [7:0][7:0] w;
        int              cyc;
        bit              with_last;
        logic [3:0]      pat;
    } vec_t;

    vec_t       vt [6];
    logic [7:0] sb [$];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_out_data"}, int'(bus.out_data), 0);
        chk({tag, "_count"}, int'(bus.count), 0);
    endtask

    task automatic load_words(input vec_t v);
        for (int k = 0; k < v.n; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = v.w[k];
            bus.start    = v.with_last && (k == v.n - 1);
            #1;
            chk("in_ready_load", int'(bus.in_ready), 1);
        end
    endtask

    task automatic push_sorted(input vec_t v);
        logic [7:0] tmp [8];
        logic [7:0] key;
        int j;
        for (int k = 0; k < v.n; k++) tmp[k] = v.w[k];
        for (int k = 1; k < v.n; k++) begin
            key = tmp[k];
            j = k - 1;
            while (j >= 0 && tmp[j] > key) begin
                tmp[j + 1] = tmp[j];
                j--;
            end
            tmp[j + 1] = key;
        end
        for (int k = 0; k < v.n; k++) sb.push_back(tmp[k]);
    endtask

    task automatic run_vec(input vec_t v);
        int sc;
        int dn;
        int t;
        int ph;
        load_words(v);
        push_sorted(v);
        if (!v.with_last) begin
            if (v.n == 8) begin
                @(negedge clk);
                bus.in_valid = 1'b1;
                bus.in_data  = 8'h00;
                bus.start    = 1'b0;
                #1;
                chk("full_in_ready", int'(bus.in_ready), 0);
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.start    = 1'b1;
            #1;
            chk("count_loaded", int'(bus.count), v.n);
        end
        sc = 0;
        dn = -1;
        for (t = 0; t < 100; t++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.start    = 1'b0;
            #1;
            if (bus.out_valid) break;
            sc++;
            if (t == 0) begin
                chk("sort_busy", int'(bus.busy), 1);
                chk("sort_in_ready", int'(bus.in_ready), 0);
            end
            if (bus.done) dn = sc;
        end
        if (t == 100) chk("sort_timeout", 0, 1);
        chk("sort_cycles", sc, v.cyc);
        chk("done_cycle", dn, v.cyc);
        ph = 0;
        while (sb.size() != 0) begin
            if (ph == 100) begin
                chk("drain_timeout", 0, 1);
                sb.delete();
                break;
            end
            bus.out_ready = v.pat[ph % 4];
            chk("out_valid", int'(bus.out_valid), 1);
            chk("out_data", int'(bus.out_data), int'(sb[0]));
            if (bus.out_ready) void'(sb.pop_front());
            ph++;
            @(negedge clk);
            #1;
        end
        bus.out_ready = 1'b0;
        chk("post_count", int'(bus.count), 0);
        chk("post_busy", int'(bus.busy), 0);
        chk("post_out_valid", int'(bus.out_valid), 0);
        chk("post_out_data", int'(bus.out_data), 0);
        chk("post_in_ready", int'(bus.in_ready), 1);
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            vt[i].w = '0;
            vt[i].with_last = 1'b0;
            vt[i].pat = 4'b1111;
        end
        vt[0].n = 4;
        vt[0].w[0] = 8'd5;
        vt[0].w[1] = 8'd3;
        vt[0].w[2] = 8'd8;
        vt[0].w[3] = 8'd1;
        vt[0].cyc = 6;
        vt[1].n = 8;
        for (int k = 0; k < 8; k++) vt[1].w[k] = 8'(k + 1);
        vt[1].cyc = 7;
        vt[1].pat = 4'b1001;
        vt[2].n = 8;
        for (int k = 0; k < 8; k++) vt[2].w[k] = 8'(255 - k);
        vt[2].cyc = 28;
        vt[2].with_last = 1'b1;
        vt[3].n = 3;
        vt[3].w[0] = 8'h10;
        vt[3].w[1] = 8'h10;
        vt[3].w[2] = 8'h05;
        vt[3].cyc = 3;
        vt[3].pat = 4'b1101;
        vt[4].n = 1;
        vt[4].w[0] = 8'h42;
        vt[4].cyc = 1;
        vt[5].n = 2;
        vt[5].w[0] = 8'd2;
        vt[5].w[1] = 8'd1;
        vt[5].cyc = 1;

        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        chk("empty_start_busy", int'(bus.busy), 0);
        chk("empty_start_count", int'(bus.count), 0);
        chk("empty_start_ready", int'(bus.in_ready), 1);

        for (int i = 0; i < 5; i++) run_vec(vt[i]);

        load_words(vt[2]);
        repeat (5) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.start    = 1'b0;
        end
        #1;
        chk("mid_sort_busy", int'(bus.busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_vec(vt[5]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
